band_playback_multi: RTL and testbench

//   Multi-band sample player: on each 44 kHz strobe, fetches one sample per band from a shared

---
 rtl/band_playback_pkg.sv | 19 +
 rtl/band_fetch_seq.sv | 76 +++++++
 rtl/band_playback_multi.sv | 148 ++++++++++++++
 tb/tb_band_playback_multi.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/band_playback_pkg.sv
// Shared types and sizing helpers for the multi-band sample player.
package band_playback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } state_t;

    function automatic int frame_latency(input int num_bands, input int bram_lat);
        return num_bands + bram_lat + 1;
    endfunction

    function automatic int calc_mem_aw(input int num_bands, input int mem_depth);
        return (num_bands * mem_depth > 1) ? $clog2(num_bands * mem_depth) : 1;
    endfunction

endpackage

// File: rtl/band_fetch_seq.sv
// Issues one ROM address per band (base accumulated by MEM_DEPTH) and tracks which
// band lane the returning ROM word belongs to.
module band_fetch_seq
    import band_playback_pkg::*;
#(
    parameter int NUM_BANDS  = 16,
    parameter int MEM_DEPTH  = 4036,
    parameter int BRAM_LAT   = 1,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_AW     = 16,
    parameter int BAND_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] ptr,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic                  cap_valid,
    output logic [BAND_W-1:0]     cap_band
);

    logic                  active;
    logic                  iss_valid;
    logic [BAND_W-1:0]     iss_band;
    logic [MEM_AW-1:0]     base;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  lat_valid [BRAM_LAT];
    logic [BAND_W-1:0]     lat_band  [BRAM_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= 1'b0;
            iss_valid <= 1'b0;
            iss_band  <= '0;
            base      <= '0;
            ptr_q     <= '0;
            mem_addr  <= '0;
        end else if (start) begin
            // Band 0 goes out on the same edge the frame starts.
            mem_addr  <= MEM_AW'(ptr);
            base      <= MEM_AW'(MEM_DEPTH);
            ptr_q     <= ptr;
            iss_valid <= 1'b1;
            iss_band  <= '0;
            active    <= (NUM_BANDS > 1);
        end else if (active) begin
            mem_addr  <= base + MEM_AW'(ptr_q);
            base      <= base + MEM_AW'(MEM_DEPTH);
            iss_valid <= 1'b1;
            iss_band  <= iss_band + BAND_W'(1);
            active    <= (iss_band + BAND_W'(1)) != BAND_W'(NUM_BANDS - 1);
        end else begin
            iss_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BRAM_LAT; i++) begin
                lat_valid[i] <= 1'b0;
                lat_band[i]  <= '0;
            end
        end else begin
            lat_valid[0] <= iss_valid;
            lat_band[0]  <= iss_band;
            for (int i = 1; i < BRAM_LAT; i++) begin
                lat_valid[i] <= lat_valid[i-1];
                lat_band[i]  <= lat_band[i-1];
            end
        end
    end

    assign cap_valid = lat_valid[BRAM_LAT-1];
    assign cap_band  = lat_band[BRAM_LAT-1];

endmodule

// File: rtl/band_playback_multi.sv
// Multi-band sample player: one ROM sample per band per strobe, packed into a frame,
// with play/stop, loop/one-shot and overrun tracking.
//
//   state | meaning
//   IDLE  | waiting for the sample strobe
//   FETCH | one ROM address issued per band
//   DRAIN | waiting out ROM read latency
//   EMIT  | frame published, pointer and controls updated
module band_playback_multi
    import band_playback_pkg::*;
#(
    parameter int NUM_BANDS  = 16,
    parameter int MEM_DEPTH  = 4036,
    parameter int DATA_W     = 16,
    parameter int BRAM_LAT   = 1,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int MEM_AW     = calc_mem_aw(NUM_BANDS, MEM_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        play,
    input  logic                        stop,
    input  logic                        loop_en,
    output logic [MEM_AW-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_dout,
    output logic [NUM_BANDS*DATA_W-1:0] data_out,
    output logic                        valid_out,
    output logic                        playing,
    output logic                        done,
    output logic                        overrun
);

    localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int CNT_W  = $clog2(frame_latency(NUM_BANDS, BRAM_LAT) + 1);

    state_t                      state;
    logic [CNT_W-1:0]            phase_cnt;
    logic [ADDR_WIDTH-1:0]       ptr;
    logic                        play_pend;
    logic                        stop_pend;
    logic [NUM_BANDS*DATA_W-1:0] frame_buf;
    logic                        cap_valid;
    logic [BAND_W-1:0]           cap_band;
    logic                        fetch_start;
    logic                        play_now;
    logic                        stop_now;

    assign fetch_start = (state == IDLE) && enable && playing;
    assign play_now    = play_pend | play;
    assign stop_now    = stop_pend | stop;

    band_fetch_seq #(
        .NUM_BANDS  (NUM_BANDS),
        .MEM_DEPTH  (MEM_DEPTH),
        .BRAM_LAT   (BRAM_LAT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_AW     (MEM_AW),
        .BAND_W     (BAND_W)
    ) u_fetch (
        .clk       (clk),
        .rst       (rst),
        .start     (fetch_start),
        .ptr       (ptr),
        .mem_addr  (mem_addr),
        .cap_valid (cap_valid),
        .cap_band  (cap_band)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            ptr       <= '0;
            play_pend <= 1'b0;
            stop_pend <= 1'b0;
            frame_buf <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            playing   <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            play_pend <= play_now;
            stop_pend <= stop_now;

            if (cap_valid)
                frame_buf[int'(cap_band)*DATA_W +: DATA_W] <= mem_dout;

            case (state)
                // Stopped frames run the same timeline so output cadence never changes.
                IDLE: if (enable) begin
                    state     <= FETCH;
                    phase_cnt <= CNT_W'(NUM_BANDS - 1);
                    frame_buf <= '0;
                end
                FETCH: begin
                    if (phase_cnt == '0) begin
                        state     <= DRAIN;
                        phase_cnt <= CNT_W'(BRAM_LAT - 1);
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (phase_cnt == '0)
                        state <= EMIT;
                    else
                        phase_cnt <= phase_cnt - CNT_W'(1);
                end
                EMIT: begin
                    state     <= IDLE;
                    data_out  <= frame_buf;
                    valid_out <= 1'b1;
                    if (playing) begin
                        if (ptr == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
                            ptr <= '0;
                            if (!loop_en) begin
                                playing <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            ptr <= ptr + ADDR_WIDTH'(1);
                        end
                    end
                    if (stop_now) begin
                        playing <= 1'b0;
                        ptr     <= '0;
                        done    <= 1'b0;
                    end else if (play_now) begin
                        playing <= 1'b1;
                        ptr     <= '0;
                        overrun <= 1'b0;
                    end
                    play_pend <= 1'b0;
                    stop_pend <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (enable && state != IDLE)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_band_playback_multi.sv
// Bench for band_playback_multi: strobe every 100 clocks, ROM word = {band, ptr},
// frames compared against a rule-level model of the player.
module tb_band_playback_multi;

    localparam int NB    = 4;
    localparam int DEPTH = 8;
    localparam int LAT   = 1;
    localparam int DW    = 16;
    localparam int MAW   = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              play = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [MAW-1:0]    mem_addr;
    logic [DW-1:0]     mem_dout = '0;
    logic [NB*DW-1:0]  data_out;
    logic              valid_out;
    logic              playing;
    logic              done;
    logic              overrun;

    band_playback_multi #(
        .NUM_BANDS (NB),
        .MEM_DEPTH (DEPTH),
        .DATA_W    (DW),
        .BRAM_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .play      (play),
        .stop      (stop),
        .loop_en   (loop_en),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .data_out  (data_out),
        .valid_out (valid_out),
        .playing   (playing),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // ROM with one clock of read latency.
    always @(posedge clk)
        mem_dout <= {4'(mem_addr / DEPTH), 12'(mem_addr % DEPTH)};

    int checks = 0;
    int failures = 0;

    // Model of player state.
    bit m_playing, m_overrun, m_play_pend, m_stop_pend;
    int m_ptr;
    logic [NB*DW-1:0] exp_data;
    bit exp_done;

    // Observations from one strobe period.
    int             ob_valid_cnt, ob_valid_iv, ob_done_cnt;
    logic [NB*DW-1:0] ob_data;
    logic           ob_done_with_valid, ob_addr_changed, ob_zero_after_rst;
    logic           ob_playing_end, ob_overrun_end;
    logic [MAW-1:0] ob_addrs [NB];

    task automatic model_reset();
        m_playing = 0; m_overrun = 0; m_play_pend = 0; m_stop_pend = 0; m_ptr = 0;
    endtask

    task automatic model_frame(input int play_off, input int stop_off, input int en2_off,
                               input bit le);
        exp_data = '0;
        if (m_playing)
            for (int k = 0; k < NB; k++) exp_data[k*DW +: DW] = {4'(k), 12'(m_ptr)};
        exp_done = 0;
        if (en2_off >= 1) m_overrun = 1;
        if (play_off >= 1 && play_off <= 6) m_play_pend = 1;
        if (stop_off >= 1 && stop_off <= 6) m_stop_pend = 1;
        if (m_playing) begin
            if (m_ptr == DEPTH - 1) begin
                m_ptr = 0;
                if (!le) begin m_playing = 0; exp_done = 1; end
            end else begin
                m_ptr++;
            end
        end
        if (m_stop_pend) begin
            m_playing = 0; m_ptr = 0; exp_done = 0;
        end else if (m_play_pend) begin
            m_playing = 1; m_ptr = 0; m_overrun = 0;
        end
        m_play_pend = 0; m_stop_pend = 0;
        if (play_off > 6) m_play_pend = 1;
        if (stop_off > 6) m_stop_pend = 1;
    endtask

    // One 100-clock strobe period; offsets are edges after T0 at which a pulse is sampled.
    task automatic run_frame(input int play_off, input int stop_off, input int en2_off,
                             input int rst_off, input bit le);
        logic [MAW-1:0] a0;
        a0 = mem_addr;
        ob_valid_cnt = 0; ob_valid_iv = -1; ob_done_cnt = 0; ob_data = '0;
        ob_done_with_valid = 0; ob_addr_changed = 0; ob_zero_after_rst = 0;
        loop_en = le;
        enable = 1'b1;
        for (int off = 1; off <= 100; off++) begin
            @(negedge clk);
            if (valid_out) begin
                ob_valid_cnt++;
                if (ob_valid_cnt == 1) begin
                    ob_valid_iv = off - 1;
                    ob_data = data_out;
                    ob_done_with_valid = done;
                end
            end
            if (done) ob_done_cnt++;
            if (mem_addr !== a0) ob_addr_changed = 1;
            if (off - 1 < NB) ob_addrs[off-1] = mem_addr;
            if (rst_off >= 0 && off == rst_off + 1)
                ob_zero_after_rst = (mem_addr === '0) && (data_out === '0) && !valid_out &&
                                    !playing && !done && !overrun;
            ob_playing_end = playing;
            ob_overrun_end = overrun;
            if (off < 100) begin
                enable = (off == en2_off);
                play   = (off == play_off);
                stop   = (off == stop_off);
                rst    = (off == rst_off);
            end
        end
    endtask

    task automatic frame(input int play_off, input int stop_off, input int en2_off, input bit le);
        model_frame(play_off, stop_off, en2_off, le);
        run_frame(play_off, stop_off, en2_off, -1, le);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_out, playing, done, overrun} !== 4'b0)
            begin failures++; $display("FAIL reset_flags got=%b exp=0000", {valid_out, playing, done, overrun}); end
        checks++;
        if (data_out !== '0 || mem_addr !== '0)
            begin failures++; $display("FAIL reset_data got data=%h addr=%0d exp 0", data_out, mem_addr); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_idle_frame();
        for (int i = 0; i < 2; i++) begin
            frame(-1, -1, -1, 1'b0);
            checks++;
            if (ob_valid_cnt != 1 || ob_valid_iv != 6)
                begin failures++; $display("FAIL idle_latency got cnt=%0d at=%0d exp 1 at 6", ob_valid_cnt, ob_valid_iv); end
            checks++;
            if (ob_data !== '0)
                begin failures++; $display("FAIL idle_data got=%h exp=0", ob_data); end
            checks++;
            if (ob_addr_changed !== 1'b0 || ob_playing_end !== 1'b0)
                begin failures++; $display("FAIL idle_addr_play got chg=%b play=%b exp 0 0", ob_addr_changed, ob_playing_end); end
        end
    endtask

    task automatic test_loop();
        frame(3, -1, -1, 1'b1);
        for (int f = 0; f < 10; f++) begin
            logic [NB*DW-1:0] spec_data;
            for (int k = 0; k < NB; k++) spec_data[k*DW +: DW] = {4'(k), 12'(f % DEPTH)};
            frame(-1, -1, -1, 1'b1);
            checks++;
            if (ob_valid_cnt != 1 || ob_valid_iv != 6 || ob_data !== spec_data || ob_data !== exp_data)
                begin failures++; $display("FAIL loop_data f=%0d got=%h at=%0d exp=%h at 6", f, ob_data, ob_valid_iv, spec_data); end
            for (int k = 0; k < NB; k++) begin
                checks++;
                if (ob_addrs[k] !== MAW'(k * DEPTH + f % DEPTH))
                    begin failures++; $display("FAIL loop_addr f=%0d k=%0d got=%0d exp=%0d", f, k, ob_addrs[k], k * DEPTH + f % DEPTH); end
            end
            checks++;
            if (ob_done_cnt != 0 || ob_playing_end !== 1'b1)
                begin failures++; $display("FAIL loop_done f=%0d got done=%0d play=%b exp 0 1", f, ob_done_cnt, ob_playing_end); end
        end
    endtask

    task automatic test_oneshot();
        frame(3, -1, -1, 1'b0);
        for (int f = 0; f < 9; f++) begin
            frame(-1, -1, -1, 1'b0);
            checks++;
            if (ob_data !== exp_data || ob_valid_iv != 6)
                begin failures++; $display("FAIL oneshot_data f=%0d got=%h exp=%h", f, ob_data, exp_data); end
            checks++;
            if (ob_done_cnt != ((f == 7) ? 1 : 0) || ob_done_with_valid !== (f == 7))
                begin failures++; $display("FAIL oneshot_done f=%0d got cnt=%0d wv=%b exp %0d", f, ob_done_cnt, ob_done_with_valid, (f == 7)); end
        end
        checks++;
        if (ob_data !== '0 || ob_playing_end !== 1'b0)
            begin failures++; $display("FAIL oneshot_end got data=%h play=%b exp 0 0", ob_data, ob_playing_end); end
    endtask

    task automatic test_stop();
        frame(3, -1, -1, 1'b1);
        for (int f = 0; f < 6; f++) begin
            int stop_off;
            stop_off = (f == 3) ? 2 : -1;
            frame(-1, stop_off, -1, 1'b1);
            checks++;
            if (ob_data !== exp_data || ob_done_cnt != 0)
                begin failures++; $display("FAIL stop_data f=%0d got=%h done=%0d exp=%h", f, ob_data, ob_done_cnt, exp_data); end
            if (f == 3) begin
                checks++;
                if (ob_data[11:0] !== 12'd3 || ob_playing_end !== 1'b0)
                    begin failures++; $display("FAIL stop_frame3 got ptr=%0d play=%b exp 3 0", ob_data[11:0], ob_playing_end); end
            end
        end
        frame(3, -1, -1, 1'b1);
        frame(-1, -1, -1, 1'b1);
        checks++;
        if (ob_data[11:0] !== 12'd0 || ob_playing_end !== 1'b1 || ob_data !== exp_data)
            begin failures++; $display("FAIL stop_restart got=%h play=%b exp=%h", ob_data, ob_playing_end, exp_data); end
    endtask

    task automatic test_overrun();
        for (int f = 0; f < 3; f++) begin
            frame(-1, -1, (f == 0) ? 3 : -1, 1'b1);
            checks++;
            if (ob_valid_cnt != 1 || ob_data !== exp_data || ob_overrun_end !== 1'b1)
                begin failures++; $display("FAIL overrun_hold f=%0d got cnt=%0d ovr=%b exp 1 1", f, ob_valid_cnt, ob_overrun_end); end
        end
        frame(3, -1, -1, 1'b1);
        checks++;
        if (ob_overrun_end !== 1'b0)
            begin failures++; $display("FAIL overrun_clear got=%b exp=0", ob_overrun_end); end
    endtask

    task automatic test_rst_mid();
        frame(-1, -1, -1, 1'b1);
        run_frame(-1, -1, -1, 3, 1'b1);
        model_reset();
        checks++;
        if (ob_valid_cnt != 0)
            begin failures++; $display("FAIL rst_mid_valid got=%0d exp=0", ob_valid_cnt); end
        checks++;
        if (ob_zero_after_rst !== 1'b1)
            begin failures++; $display("FAIL rst_mid_zero got=%b exp=1", ob_zero_after_rst); end
        frame(3, -1, -1, 1'b1);
        frame(-1, -1, -1, 1'b1);
        checks++;
        if (ob_data !== exp_data || ob_data[11:0] !== 12'd0 || ob_playing_end !== 1'b1)
            begin failures++; $display("FAIL rst_restart got=%h exp=%h", ob_data, exp_data); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            int p_off, s_off, e_off;
            bit le;
            p_off = -1; s_off = -1; e_off = -1;
            if ($urandom_range(0, 9) < 3) p_off = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(10, 90));
            if ($urandom_range(0, 9) < 2) s_off = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(10, 90));
            if ($urandom_range(0, 9) < 1) e_off = int'($urandom_range(1, 5));
            le = ($urandom_range(0, 3) != 0);
            frame(p_off, s_off, e_off, le);
            checks++;
            if (ob_valid_cnt != 1 || ob_valid_iv != 6 || ob_data !== exp_data)
                begin failures++; $display("FAIL rand_data f=%0d got=%h at=%0d exp=%h", f, ob_data, ob_valid_iv, exp_data); end
            checks++;
            if (ob_done_cnt != int'(exp_done) || ob_done_with_valid !== exp_done)
                begin failures++; $display("FAIL rand_done f=%0d got=%0d exp=%0d", f, ob_done_cnt, exp_done); end
            checks++;
            if (ob_playing_end !== m_playing || ob_overrun_end !== m_overrun)
                begin failures++; $display("FAIL rand_status f=%0d got play=%b ovr=%b exp %b %b", f, ob_playing_end, ob_overrun_end, m_playing, m_overrun); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_loop();
        test_oneshot();
        test_stop();
        test_overrun();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
